// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO controllers: Gray/binary
// conversion and pointer-width arithmetic.
package fifo_pkg;

  // Widest pointer the conversion helpers handle; callers cast to their width.
  localparam int max_ptr_w = 32;

  // Pointer width for a given depth: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Binary to reflected Gray code. Unused upper bits must be zero.
  function automatic logic [max_ptr_w-1:0] bin2gray(input logic [max_ptr_w-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [max_ptr_w-1:0] gray2bin(input logic [max_ptr_w-1:0] g);
    logic [max_ptr_w-1:0] b;
    b[max_ptr_w-1] = g[max_ptr_w-1];
    for (int i = max_ptr_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_ptr_sync.sv
// N-stage flop chain carrying a Gray pointer across a clock domain.
// Shared by the write- and read-side controllers.
module ptr_sync #(
  parameter int width  = 4,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [stages-1:0][width-1:0] chain;

  // Shift the asynchronous pointer through the synchroniser stages.
  always_ff @(posedge clk) begin
    // NOTE: the chain is reset with the controller so a stale read pointer
    // from before reset can never leak into the level calculation.
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[stages-2:0], d};
    end
  end

  assign q = chain[stages-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of the asynchronous FIFO (write clock domain only):
// binary/Gray write pointers, read-pointer synchroniser, full/almost-full/
// level flags and a sticky overflow flag.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int width        = 32,
  parameter int depth        = 8,
  parameter int adr_width    = $clog2(depth),
  parameter int sync_stages  = 2,
  parameter int afull_thresh = depth - 2
) (
  input  logic                 clk_w,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 clr_overflow,
  input  logic [adr_width:0]   rd_ptr_gray_async,
  output logic                 write,
  output logic [adr_width-1:0] write_adr,
  output logic [adr_width:0]   wr_ptr_gray,
  output logic                 FIFO_full,
  output logic                 almost_full,
  output logic [adr_width:0]   wr_level,
  output logic                 overflow
);

  localparam int ptr_w = adr_width + 1;
  localparam logic [ptr_w-1:0] depth_lvl  = ptr_w'(depth);
  localparam logic [ptr_w-1:0] afull_lvl  = ptr_w'(afull_thresh);

  // Reject configurations the pointer arithmetic cannot support.
  if (width < 1 || depth < 4 || (depth & (depth - 1)) != 0 ||
      ptr_w != ptr_width(depth) || sync_stages < 2 ||
      afull_thresh < 1 || afull_thresh > depth) begin : g_param_check
    $error("fifo_write_ctrl: illegal parameter combination");
  end

  logic [ptr_w-1:0] wptr_bin;
  logic [ptr_w-1:0] wptr_nxt;
  logic [ptr_w-1:0] rd_ptr_gray_sync;
  logic [ptr_w-1:0] rptr_bin;
  logic [ptr_w-1:0] wr_level_nxt;

  ptr_sync #(
    .width  (ptr_w),
    .stages (sync_stages)
  ) u_rd_sync (
    .clk   (clk_w),
    .reset (reset),
    .d     (rd_ptr_gray_async),
    .q     (rd_ptr_gray_sync)
  );

  // Accept only against the registered full flag; never write during reset.
  assign write     = wr_en & ~FIFO_full & ~reset;
  assign write_adr = wptr_bin[adr_width-1:0];

  assign wptr_nxt     = wptr_bin + ptr_w'(write);
  assign rptr_bin     = ptr_w'(gray2bin(max_ptr_w'(rd_ptr_gray_sync)));
  // The synchronised read pointer lags, so this level can only overestimate.
  assign wr_level_nxt = wptr_nxt - rptr_bin;

  // Advance pointers and register all flags from the post-write pointer.
  always_ff @(posedge clk_w) begin
    // NOTE: every register here uses <= so all flags see the same
    // pre-edge pointer values regardless of statement order.
    if (reset) begin
      wptr_bin    <= '0;
      wr_ptr_gray <= '0;
      wr_level    <= '0;
      FIFO_full   <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wptr_bin    <= wptr_nxt;
      wr_ptr_gray <= ptr_w'(bin2gray(max_ptr_w'(wptr_nxt)));
      wr_level    <= wr_level_nxt;
      FIFO_full   <= (wr_level_nxt == depth_lvl);
      almost_full <= (wr_level_nxt >= afull_lvl);
      // Set wins over clear so a rejected write is never lost.
      if (wr_en && FIFO_full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl (depth 8, almost-full at 6).
module tb_fifo_write_ctrl;

  logic       clk_w;
  logic       reset;
  logic       wr_en;
  logic       clr_overflow;
  logic [3:0] rd_in;
  logic       write;
  logic [2:0] write_adr;
  logic [3:0] wr_ptr_gray;
  logic       FIFO_full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int adr;
    int gray;
  } exp_t;
  exp_t sb[$];

  // Reference model state.
  int m_wptr, m_level, m_s1, m_s2;
  bit m_full, m_afull, m_ovf;

  fifo_write_ctrl #(
    .width        (32),
    .depth        (8),
    .sync_stages  (2),
    .afull_thresh (6)
  ) dut (
    .clk_w             (clk_w),
    .reset             (reset),
    .wr_en             (wr_en),
    .clr_overflow      (clr_overflow),
    .rd_ptr_gray_async (rd_in),
    .write             (write),
    .write_adr         (write_adr),
    .wr_ptr_gray       (wr_ptr_gray),
    .FIFO_full         (FIFO_full),
    .almost_full       (almost_full),
    .wr_level          (wr_level),
    .overflow          (overflow)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int g_of(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int b_of(input int g);
    int b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    return b & 15;
  endfunction

  // One clock with inputs already driven: checks combinational outputs
  // mid-cycle, then registered outputs just after the edge.
  task automatic tick();
    bit   ew;
    bit   got;
    exp_t e;
    int   prev_gray;
    ew = wr_en && !m_full && !reset;
    if (ew) sb.push_back('{adr: m_wptr & 7, gray: g_of((m_wptr + 1) & 15)});
    @(negedge clk_w);
    check("write", int'(write), int'(ew));
    got = 1'b0;
    if (write) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        got = 1'b1;
        check("write_adr", int'(write_adr), e.adr);
      end
    end else if (ew && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    prev_gray = int'(wr_ptr_gray);
    @(posedge clk_w);
    if (reset) begin
      m_wptr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      m_s1 = 0; m_s2 = 0;
    end else begin
      if (wr_en && m_full) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      m_wptr  = (m_wptr + int'(ew)) & 15;
      m_level = (m_wptr - b_of(m_s2)) & 15;
      m_full  = (m_level == 8);
      m_afull = (m_level >= 6);
      m_s2    = m_s1;
      m_s1    = int'(rd_in);
    end
    #1;
    if (got) check("gray_sb", int'(wr_ptr_gray), e.gray);
    if (!reset) check("gray_step", $countones(int'(wr_ptr_gray) ^ prev_gray), int'(ew));
    check("full", int'(FIFO_full), int'(m_full));
    check("afull", int'(almost_full), int'(m_afull));
    check("level", int'(wr_level), m_level);
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_wptr = 0; m_level = 0; m_s1 = 0; m_s2 = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
    reset = 1'b1; wr_en = 1'b0; clr_overflow = 1'b0; rd_in = 4'b0000;
    tick();
    tick();
    check("rst_gray", int'(wr_ptr_gray), 0);
    check("rst_adr", int'(write_adr), 0);
    check("rst_level", int'(wr_level), 0);
    check("rst_full", int'(FIFO_full), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b0;

    // Fill from empty.
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) check("afull_after5", int'(almost_full), 0);
      if (i == 5) check("afull_after6", int'(almost_full), 1);
    end
    check("fill_full", int'(FIFO_full), 1);
    check("fill_level", int'(wr_level), 8);
    check("fill_gray", int'(wr_ptr_gray), 4'b1100);

    // Overflow set / clear / set-priority.
    tick();
    check("ovf_set", int'(overflow), 1);
    check("ovf_frozen_gray", int'(wr_ptr_gray), 4'b1100);
    wr_en = 1'b0; clr_overflow = 1'b1;
    tick();
    check("ovf_clr", int'(overflow), 0);
    wr_en = 1'b1;
    tick();
    check("ovf_set_priority", int'(overflow), 1);
    wr_en = 1'b0;
    tick();
    clr_overflow = 1'b0;

    // Read pointer advances to 3 while full.
    rd_in = 4'b0010;
    tick();
    check("rd_lat_full1", int'(FIFO_full), 1);
    tick();
    check("rd_lat_full2", int'(FIFO_full), 1);
    tick();
    check("rd_lat_full3", int'(FIFO_full), 0);
    check("rd_lat_level", int'(wr_level), 5);
    check("rd_lat_afull", int'(almost_full), 0);

    // Wrap: 20 writes with the reader trailing.
    for (int i = 0; i < 20; i++) begin
      rd_in = 4'(g_of((m_wptr - 4) & 15));
      wr_en = 1'b1;
      tick();
      check("wrap_no_full", int'(FIFO_full), 0);
    end
    check("wrap_gray", int'(wr_ptr_gray), 4'b1010);

    // Reset mid-stream with wr_en held.
    reset = 1'b1; rd_in = 4'b0000;
    tick();
    check("mid_rst_adr", int'(write_adr), 0);
    check("mid_rst_gray", int'(wr_ptr_gray), 0);
    check("mid_rst_afull", int'(almost_full), 0);
    reset = 1'b0;
    check("resume_adr", int'(write_adr), 0);
    for (int i = 0; i < 7; i++) tick();
    check("sim_level7", int'(wr_level), 7);

    // Read advance lands at the synchroniser output on the same edge as a write.
    wr_en = 1'b0; rd_in = 4'(g_of(1));
    tick();
    tick();
    wr_en = 1'b1;
    tick();
    check("sim_level_net", int'(wr_level), 7);
    check("sim_no_full", int'(FIFO_full), 0);
    wr_en = 1'b0;
    tick();
    tick();
    check("sim_level_settled", int'(wr_level), 7);
    check("sim_no_full_settled", int'(FIFO_full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
